// File: rtl/axi_lite_led_regs.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_led_regs
// Purpose  : AXI4-Lite slave with NUM_REGS 32-bit registers, byte strobes,
//            SLVERR decode, a read-only STATUS word and an LED driver with an
//            optional blink mode.
// Revision : 1.0  initial parametrised release
// ----------------------------------------------------------------------------
// Ports
//   ACLK, ARESET           clock, asynchronous active-high reset
//   S_AXI_AW* / S_AXI_W*   write address / write data channels
//   S_AXI_B*               write response channel (00 OKAY, 10 SLVERR)
//   S_AXI_AR* / S_AXI_R*   read address / read data channels
//   led_o                  registered LED drive
// Register map (word index)
//   0 LED_DATA rw | 1 CTRL rw (bit0 blink_en) | 2 BLINK_DIV rw
//   3 STATUS ro   | 4..NUM_REGS-1 scratch rw
// ============================================================================
module axi_lite_led_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_REGS           = 8,
    parameter int LED_WIDTH          = 8
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [LED_WIDTH-1:0]            led_o
);

    localparam int c_idx_w   = $clog2(NUM_REGS);
    localparam int c_idx_lsb = 2;

    localparam logic [c_idx_w-1:0] c_idx_led    = c_idx_w'(0);
    localparam logic [c_idx_w-1:0] c_idx_ctrl   = c_idx_w'(1);
    localparam logic [c_idx_w-1:0] c_idx_div    = c_idx_w'(2);
    localparam logic [c_idx_w-1:0] c_idx_status = c_idx_w'(3);

    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;

    localparam logic [0:0] c_w_idle = 1'b0;
    localparam logic [0:0] c_w_resp = 1'b1;
    localparam logic [0:0] c_r_idle = 1'b0;
    localparam logic [0:0] c_r_data = 1'b1;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [31:0]          r_regs [NUM_REGS];
    logic                 r_ready_en;
    logic [0:0]           r_wstate;
    logic [0:0]           w_wstate_nxt;
    logic [0:0]           r_rstate;
    logic [0:0]           w_rstate_nxt;

    logic                 r_aw_done;
    logic                 r_w_done;
    logic [c_idx_w-1:0]   r_aw_idx;
    logic                 r_aw_err;
    logic [31:0]          r_wdata;
    logic [3:0]           r_wstrb;
    logic [1:0]           r_bresp;

    logic [31:0]          r_rdata;
    logic [1:0]           r_rresp;

    logic [31:0]          r_cnt;
    logic                 r_phase;
    logic [LED_WIDTH-1:0] r_led;

    logic                 w_aw_oor;
    logic                 w_ar_oor;
    logic [c_idx_w-1:0]   w_aw_idx;
    logic [c_idx_w-1:0]   w_ar_idx;
    logic                 w_aw_err;
    logic                 w_aw_acc;
    logic                 w_w_acc;
    logic                 w_ar_acc;
    logic                 w_commit;
    logic [c_idx_w-1:0]   w_wr_idx;
    logic                 w_wr_err;
    logic [31:0]          w_wr_data;
    logic [3:0]           w_wr_strb;
    logic [31:0]          w_merged;
    logic                 w_reg_write;
    logic [31:0]          w_rd_data;
    logic                 w_blink_en;
    logic                 w_blink_clr;

    // Protection bits and the byte offset inside a word carry no meaning here.
    logic w_unused;
    assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // ------------------------------------------------------------------
    // Address decode: any address bit above the word index is an error
    // ------------------------------------------------------------------
    assign w_aw_idx = S_AXI_AWADDR[c_idx_lsb +: c_idx_w];
    assign w_ar_idx = S_AXI_ARADDR[c_idx_lsb +: c_idx_w];

    generate
        if (C_S_AXI_ADDR_WIDTH > c_idx_lsb + c_idx_w) begin : g_upper_bits
            assign w_aw_oor = |S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:c_idx_lsb+c_idx_w];
            assign w_ar_oor = |S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:c_idx_lsb+c_idx_w];
        end else begin : g_no_upper_bits
            assign w_aw_oor = 1'b0;
            assign w_ar_oor = 1'b0;
        end
    endgenerate

    // STATUS is read-only, so a write to it is rejected like an unmapped one.
    assign w_aw_err = w_aw_oor || (w_aw_idx == c_idx_status);

    // ------------------------------------------------------------------
    // Handshakes. READYs stay low until the first edge after reset release.
    // ------------------------------------------------------------------
    assign S_AXI_AWREADY = r_ready_en && (r_wstate == c_w_idle) && !r_aw_done;
    assign S_AXI_WREADY  = r_ready_en && (r_wstate == c_w_idle) && !r_w_done;
    assign S_AXI_ARREADY = r_ready_en && (r_rstate == c_r_idle);

    assign w_aw_acc = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_w_acc  = S_AXI_WVALID  && S_AXI_WREADY;
    assign w_ar_acc = S_AXI_ARVALID && S_AXI_ARREADY;

    // Commit on the edge that completes the AW/W pair, whichever came first.
    assign w_commit = (r_wstate == c_w_idle)
                   && (w_aw_acc || r_aw_done)
                   && (w_w_acc  || r_w_done)
                   && (w_aw_acc || w_w_acc);

    assign w_wr_idx  = w_aw_acc ? w_aw_idx    : r_aw_idx;
    assign w_wr_err  = w_aw_acc ? w_aw_err    : r_aw_err;
    assign w_wr_data = w_w_acc  ? S_AXI_WDATA : r_wdata;
    assign w_wr_strb = w_w_acc  ? S_AXI_WSTRB : r_wstrb;

    assign w_reg_write = w_commit && !w_wr_err;

    always_comb begin
        w_merged = r_regs[w_wr_idx];
        for (int b = 0; b < 4; b++) begin
            if (w_wr_strb[b]) begin
                w_merged[8*b +: 8] = w_wr_data[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wstate <= c_w_idle;
        end else begin
            r_wstate <= w_wstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            c_w_idle: if (w_commit)     w_wstate_nxt = c_w_resp;
            c_w_resp: if (S_AXI_BREADY) w_wstate_nxt = c_w_idle;
            default:                    w_wstate_nxt = c_w_idle;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_ready_en <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_aw_idx   <= '0;
            r_aw_err   <= 1'b0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bresp    <= c_resp_okay;
        end else begin
            r_ready_en <= 1'b1;
            if (w_commit) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                r_bresp   <= w_wr_err ? c_resp_slverr : c_resp_okay;
            end else begin
                if (w_aw_acc) begin
                    r_aw_done <= 1'b1;
                    r_aw_idx  <= w_aw_idx;
                    r_aw_err  <= w_aw_err;
                end
                if (w_w_acc) begin
                    r_w_done <= 1'b1;
                    r_wdata  <= S_AXI_WDATA;
                    r_wstrb  <= S_AXI_WSTRB;
                end
            end
        end
    end

    assign S_AXI_BVALID = (r_wstate == c_w_resp);
    assign S_AXI_BRESP  = r_bresp;

    // ------------------------------------------------------------------
    // Register bank. CTRL keeps only blink_en so its other bits read 0.
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_reg_write) begin
            if (w_wr_idx == c_idx_ctrl) begin
                r_regs[w_wr_idx] <= {31'd0, w_merged[0]};
            end else begin
                r_regs[w_wr_idx] <= w_merged;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read FSM. Data is sampled from the pre-edge register contents, so a
    // read colliding with a commit returns the old value.
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_data = '0;
        if (!w_ar_oor) begin
            if (w_ar_idx == c_idx_status) begin
                w_rd_data = {8'h01, 8'(NUM_REGS), 15'd0, r_phase};
            end else begin
                w_rd_data = r_regs[w_ar_idx];
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rstate <= c_r_idle;
        end else begin
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            c_r_idle: if (w_ar_acc)     w_rstate_nxt = c_r_data;
            c_r_data: if (S_AXI_RREADY) w_rstate_nxt = c_r_idle;
            default:                    w_rstate_nxt = c_r_idle;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rdata <= '0;
            r_rresp <= c_resp_okay;
        end else if (w_ar_acc) begin
            r_rdata <= w_rd_data;
            r_rresp <= w_ar_oor ? c_resp_slverr : c_resp_okay;
        end
    end

    assign S_AXI_RVALID = (r_rstate == c_r_data);
    assign S_AXI_RDATA  = r_rdata;
    assign S_AXI_RRESP  = r_rresp;

    // ------------------------------------------------------------------
    // Blink generator: half-period of BLINK_DIV+1 cycles while enabled.
    // A commit to CTRL or BLINK_DIV restarts the count.
    // ------------------------------------------------------------------
    assign w_blink_en  = r_regs[c_idx_ctrl][0];
    assign w_blink_clr = w_reg_write
                      && ((w_wr_idx == c_idx_ctrl) || (w_wr_idx == c_idx_div));

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (!w_blink_en) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (w_blink_clr) begin
            r_cnt   <= '0;
        end else if (r_cnt == r_regs[c_idx_div]) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + 32'd1;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_led <= '0;
        end else begin
            r_led <= r_phase ? r_regs[c_idx_led][LED_WIDTH-1:0] : '0;
        end
    end

    assign led_o = r_led;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_led_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_led_regs
// Purpose  : Self-checking bench for axi_lite_led_regs (NUM_REGS=8, AW=6,
//            LED_WIDTH=8): reset state, randomized traffic against a register
//            array model, a vector table, and hand-written corner sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_axi_lite_led_regs;

    localparam int NUM_REGS = 8;
    localparam int AW       = 6;
    localparam int LEDW     = 8;
    localparam logic [31:0] c_status = 32'h0108_0001;

    logic            ACLK = 1'b0;
    logic            ARESET = 1'b1;
    logic [AW-1:0]   S_AXI_AWADDR = '0;
    logic [2:0]      S_AXI_AWPROT = '0;
    logic            S_AXI_AWVALID = 1'b0;
    logic            S_AXI_AWREADY;
    logic [31:0]     S_AXI_WDATA = '0;
    logic [3:0]      S_AXI_WSTRB = '0;
    logic            S_AXI_WVALID = 1'b0;
    logic            S_AXI_WREADY;
    logic [1:0]      S_AXI_BRESP;
    logic            S_AXI_BVALID;
    logic            S_AXI_BREADY = 1'b0;
    logic [AW-1:0]   S_AXI_ARADDR = '0;
    logic [2:0]      S_AXI_ARPROT = '0;
    logic            S_AXI_ARVALID = 1'b0;
    logic            S_AXI_ARREADY;
    logic [31:0]     S_AXI_RDATA;
    logic [1:0]      S_AXI_RRESP;
    logic            S_AXI_RVALID;
    logic            S_AXI_RREADY = 1'b0;
    logic [LEDW-1:0] led_o;

    axi_lite_led_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(AW),
        .NUM_REGS(NUM_REGS),
        .LED_WIDTH(LEDW)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .led_o(led_o)
    );

    always #5 ACLK = ~ACLK;

    int n_tests = 0;
    int n_fail  = 0;
    int b_hs    = 0;

    always @(posedge ACLK) begin
        if (S_AXI_BVALID && S_AXI_BREADY) b_hs <= b_hs + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // Reference register contents, in the bench's own terms.
    logic [31:0] mem [NUM_REGS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             output logic [1:0] resp, output int early_b);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_hs, w_hs;
        int cyc = 0;
        early_b = 0;
        S_AXI_AWADDR = addr;
        S_AXI_WDATA  = data;
        S_AXI_WSTRB  = strb;
        S_AXI_BREADY = 1'b1;
        while (!(aw_done && w_done) && cyc < 60) begin
            S_AXI_AWVALID = (cyc >= aw_dly) && !aw_done;
            S_AXI_WVALID  = (cyc >= w_dly) && !w_done;
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            if (S_AXI_BVALID) early_b++;
            tick();
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done  = 1;
            cyc++;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        check("wr_addr_data_handshake", 32'({aw_done, w_done}), 32'd3);
        cyc = 0;
        while (!S_AXI_BVALID && cyc < 60) begin
            tick();
            cyc++;
        end
        check("wr_bvalid_seen", 32'(S_AXI_BVALID), 32'd1);
        resp = S_AXI_BRESP;
        tick();
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        bit hs = 0;
        int cyc = 0;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = 1'b1;
        while (!hs && cyc < 60) begin
            hs = S_AXI_ARREADY;
            tick();
            cyc++;
        end
        S_AXI_ARVALID = 1'b0;
        check("rd_addr_handshake", 32'(hs), 32'd1);
        cyc = 0;
        while (!S_AXI_RVALID && cyc < 60) begin
            tick();
            cyc++;
        end
        check("rd_rvalid_seen", 32'(S_AXI_RVALID), 32'd1);
        data = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        tick();
        S_AXI_RREADY = 1'b0;
    endtask

    typedef struct {
        logic          do_wr;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    strb;
        logic [1:0]    exp_b;
        logic [31:0]   exp_r;
        logic [1:0]    exp_rr;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    initial begin
        logic [1:0]  bresp, rresp;
        logic [31:0] rdata;
        int          early;
        int          snap;

        // ---------------- reset state ----------------
        #2;
        check("rst_bvalid",  32'(S_AXI_BVALID),  32'd0);
        check("rst_rvalid",  32'(S_AXI_RVALID),  32'd0);
        check("rst_rdata",   S_AXI_RDATA,        32'd0);
        check("rst_bresp",   32'(S_AXI_BRESP),   32'd0);
        check("rst_rresp",   32'(S_AXI_RRESP),   32'd0);
        check("rst_led",     32'(led_o),         32'd0);
        repeat (3) tick();
        check("rst_readys", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'd0);
        ARESET = 1'b0;
        check("release_readys_low", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'd0);
        tick();
        check("release_readys_high", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'd7);

        // ---------------- randomized traffic vs model ----------------
        for (int i = 0; i < NUM_REGS; i++) mem[i] = '0;
        for (int n = 0; n < 150; n++) begin
            logic [AW-1:0] addr;
            logic [31:0]   data;
            logic [3:0]    strb;
            int            idx;
            bit            bad;
            logic [1:0]    exp_b;
            if ($urandom_range(0, 7) == 0) addr = AW'($urandom_range(0, (1 << AW) - 1));
            else                           addr = AW'($urandom_range(0, NUM_REGS * 4 - 1));
            idx  = int'(addr) / 4;
            bad  = (int'(addr) >= NUM_REGS * 4);
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                if (idx == 1) data[0] = 1'b0;   // keep blinking off so STATUS stays predictable
                exp_b = (bad || idx == 3) ? 2'b10 : 2'b00;
                axi_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3), bresp, early);
                check($sformatf("rand_bresp[%0d]", n), 32'(bresp), 32'(exp_b));
                if (exp_b == 2'b00) begin
                    for (int b = 0; b < 4; b++)
                        if (strb[b]) mem[idx][8*b +: 8] = data[8*b +: 8];
                    if (idx == 1) mem[1] = mem[1] & 32'h1;
                end
            end else begin
                axi_read(addr, rdata, rresp);
                if (bad) begin
                    check($sformatf("rand_rdata[%0d]", n), rdata, 32'd0);
                    check($sformatf("rand_rresp[%0d]", n), 32'(rresp), 32'd2);
                end else begin
                    check($sformatf("rand_rdata[%0d]", n), rdata, (idx == 3) ? c_status : mem[idx]);
                    check($sformatf("rand_rresp[%0d]", n), 32'(rresp), 32'd0);
                end
            end
        end

        // ---------------- vector table ----------------
        vecs[0]  = '{1'b1, 6'h00, 32'h1,         4'hF, 2'b00, 32'h1,         2'b00};
        vecs[1]  = '{1'b1, 6'h04, 32'h2,         4'hF, 2'b00, 32'h0,         2'b00}; // only blink_en kept
        vecs[2]  = '{1'b1, 6'h08, 32'h3,         4'hF, 2'b00, 32'h3,         2'b00};
        vecs[3]  = '{1'b1, 6'h10, 32'hA5A5,      4'hF, 2'b00, 32'hA5A5,      2'b00};
        vecs[4]  = '{1'b1, 6'h14, 32'hA5A5,      4'hF, 2'b00, 32'hA5A5,      2'b00};
        vecs[5]  = '{1'b1, 6'h18, 32'hA5A5,      4'hF, 2'b00, 32'hA5A5,      2'b00};
        vecs[6]  = '{1'b1, 6'h1C, 32'hA5A5,      4'hF, 2'b00, 32'hA5A5,      2'b00};
        vecs[7]  = '{1'b0, 6'h0C, 32'h0,         4'h0, 2'b00, c_status,      2'b00};
        vecs[8]  = '{1'b1, 6'h00, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'hFFFF_FFFF, 2'b00};
        vecs[9]  = '{1'b1, 6'h00, 32'h0,         4'h2, 2'b00, 32'hFFFF_00FF, 2'b00};
        vecs[10] = '{1'b1, 6'h20, 32'hDEAD,      4'hF, 2'b10, 32'h0,         2'b10};
        vecs[11] = '{1'b1, 6'h0C, 32'h1234,      4'hF, 2'b10, c_status,      2'b00};
        vecs[12] = '{1'b0, 6'h03, 32'h0,         4'h0, 2'b00, 32'hFFFF_00FF, 2'b00};
        vecs[13] = '{1'b0, 6'h10, 32'h0,         4'h0, 2'b00, 32'hA5A5,      2'b00};
        vecs[14] = '{1'b0, 6'h3F, 32'h0,         4'h0, 2'b00, 32'h0,         2'b10};
        vecs[15] = '{1'b1, 6'h3C, 32'h5555,      4'hF, 2'b10, 32'h0,         2'b10};
        vecs[16] = '{1'b0, 6'h1C, 32'h0,         4'h0, 2'b00, 32'hA5A5,      2'b00};
        vecs[17] = '{1'b1, 6'h04, 32'hFFFF_FFFE, 4'hF, 2'b00, 32'h0,         2'b00};
        vecs[18] = '{1'b0, 6'h08, 32'h0,         4'h0, 2'b00, 32'h3,         2'b00};
        for (int v = 0; v < NVEC; v++) begin
            if (vecs[v].do_wr) begin
                axi_write(vecs[v].addr, vecs[v].wdata, vecs[v].strb, 0, 0, bresp, early);
                check($sformatf("vec%0d_bresp", v), 32'(bresp), 32'(vecs[v].exp_b));
            end
            axi_read(vecs[v].addr, rdata, rresp);
            check($sformatf("vec%0d_rdata", v), rdata, vecs[v].exp_r);
            check($sformatf("vec%0d_rresp", v), 32'(rresp), 32'(vecs[v].exp_rr));
        end

        // ---------------- read/write collision on the same word ----------------
        S_AXI_AWADDR = 6'h10; S_AXI_WDATA = 32'h1234_5678; S_AXI_WSTRB = 4'hF;
        S_AXI_ARADDR = 6'h10;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
        check("coll_readys", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'd7);
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        check("coll_valids", 32'({S_AXI_BVALID, S_AXI_RVALID}), 32'd3);
        check("coll_old_data", S_AXI_RDATA, 32'hA5A5);
        S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
        axi_read(6'h10, rdata, rresp);
        check("coll_new_data", rdata, 32'h1234_5678);

        // ---------------- W before AW, then AW before W ----------------
        snap = b_hs;
        axi_write(6'h14, 32'h11, 4'hF, 3, 0, bresp, early);
        repeat (3) tick();
        check("w_first_bresp", 32'(bresp), 32'd0);
        check("w_first_no_early_b", 32'(early), 32'd0);
        check("w_first_one_b", 32'(b_hs - snap), 32'd1);
        snap = b_hs;
        axi_write(6'h18, 32'h22, 4'hF, 0, 3, bresp, early);
        repeat (3) tick();
        check("aw_first_bresp", 32'(bresp), 32'd0);
        check("aw_first_no_early_b", 32'(early), 32'd0);
        check("aw_first_one_b", 32'(b_hs - snap), 32'd1);
        axi_read(6'h14, rdata, rresp);
        check("w_first_data", rdata, 32'h11);
        axi_read(6'h18, rdata, rresp);
        check("aw_first_data", rdata, 32'h22);

        // ---------------- blink: 5-cycle half period ----------------
        begin
            logic [LEDW-1:0] s [60];
            int trans [$];
            int bad_val = 0;
            axi_write(6'h00, 32'h3C, 4'hF, 0, 0, bresp, early);
            axi_write(6'h08, 32'd4,  4'hF, 0, 0, bresp, early);
            axi_write(6'h04, 32'd1,  4'hF, 0, 0, bresp, early);
            for (int c = 0; c < 60; c++) begin
                s[c] = led_o;
                if (s[c] != 8'h3C && s[c] != 8'h00) bad_val++;
                if (c > 0 && s[c] != s[c-1]) trans.push_back(c);
                tick();
            end
            check("blink_values", 32'(bad_val), 32'd0);
            check("blink_toggles", 32'(trans.size() >= 8), 32'd1);
            for (int k = 0; k + 1 < trans.size(); k++)
                check($sformatf("blink_run%0d", k), 32'(trans[k+1] - trans[k]), 32'd5);
        end
        begin
            int not_steady = 0;
            axi_write(6'h04, 32'd0, 4'hF, 0, 0, bresp, early);
            repeat (3) tick();
            for (int c = 0; c < 12; c++) begin
                if (led_o != 8'h3C) not_steady++;
                tick();
            end
            check("blink_off_steady", 32'(not_steady), 32'd0);
        end

        // ---------------- reset during pending responses ----------------
        S_AXI_AWADDR = 6'h10; S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 6'h00; S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        repeat (10) tick();
        check("stall_bvalid", 32'(S_AXI_BVALID), 32'd1);
        check("stall_rvalid", 32'(S_AXI_RVALID), 32'd1);
        check("stall_rdata",  S_AXI_RDATA, 32'h3C);
        check("stall_led",    32'(led_o), 32'h3C);
        #3;
        ARESET = 1'b1;
        #1;
        check("arst_bvalid", 32'(S_AXI_BVALID), 32'd0);
        check("arst_rvalid", 32'(S_AXI_RVALID), 32'd0);
        check("arst_led",    32'(led_o), 32'd0);
        check("arst_readys", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'd0);
        tick();
        ARESET = 1'b0;
        check("arst_release_low", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'd0);
        tick();
        check("arst_release_high", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'd7);
        axi_read(6'h00, rdata, rresp);
        check("arst_led_data_cleared", rdata, 32'd0);
        axi_read(6'h10, rdata, rresp);
        check("arst_scratch_cleared", rdata, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
